led_ctrl: RTL



---
 rtl/led_ctrl_if.sv | 22 ++
 rtl/led_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/led_ctrl_if.sv
// Register write port into the LED controller: single-beat valid/ready writes.
// The master holds valid/addr/data until ready; the slave accepts on valid & ready.
interface led_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/led_ctrl.sv
// LED bank owner: shows CONFIG_ID for a boot window, then CPU-driven static/blink/ID modes.
// led_o is registered (a write shows one edge after acceptance); writes stall (ready=0) during boot only.
module led_ctrl #(
    parameter logic [31:0] CONFIG_ID   = 32'h0000_002A,
    parameter int unsigned BOOT_CYCLES = 1024,
    parameter int unsigned PRESCALE_W  = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    led_ctrl_if.slave       wr,
    output logic [6:0]      led_o,
    output logic            boot_o
);

    localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_CFGID  = 2'd2;

    logic [0:0]            state;
    logic [CNT_W-1:0]      boot_cnt;
    logic [6:0]            led_val;
    logic [1:0]            mode;
    logic [PRESCALE_W-1:0] period;
    logic [PRESCALE_W-1:0] presc;
    logic                  phase;
    logic                  wr_fire;
    logic                  blink_run;
    logic [6:0]            led_nxt;

    assign boot_o      = (state == ST_BOOT);
    assign wr.wr_ready = (state == ST_RUN);
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign blink_run   = (state == ST_RUN) && (mode == MODE_BLINK);

    // Mode 3 is reserved and falls through to the static source.
    always_comb begin
        led_nxt = led_val;
        if (state == ST_BOOT || mode == MODE_CFGID) begin
            led_nxt = CONFIG_ID[6:0];
        end else if (mode == MODE_BLINK) begin
            led_nxt = phase ? led_val : 7'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
            led_val  <= '0;
            mode     <= MODE_STATIC;
            period   <= '1;
            presc    <= '1;
            phase    <= 1'b1;
            led_o    <= '0;
        end else begin
            if (state == ST_BOOT) begin
                boot_cnt <= boot_cnt + 1'b1;
                if (boot_cnt == BOOT_LAST) begin
                    state <= ST_RUN;
                end
            end

            if (blink_run) begin
                if (presc == '0) begin
                    presc <= period;
                    phase <= ~phase;
                end else begin
                    presc <= presc - 1'b1;
                end
            end

            // Register writes override the prescaler update above; a period write
            // landing on the wrap edge still lets the phase toggle through.
            if (wr_fire) begin
                case (wr.wr_addr)
                    2'd0: led_val <= wr.wr_data[6:0];
                    2'd1: begin
                        mode <= wr.wr_data[1:0];
                        if (wr.wr_data[1:0] == MODE_BLINK) begin
                            phase <= 1'b1;
                            presc <= period;
                        end
                    end
                    2'd2: begin
                        period[7:0] <= wr.wr_data;
                        presc       <= {period[15:8], wr.wr_data};
                    end
                    default: begin
                        period[15:8] <= wr.wr_data;
                        presc        <= {wr.wr_data, period[7:0]};
                    end
                endcase
            end

            led_o <= led_nxt;
        end
    end

endmodule
